// File: rtl/pe_seq_inner.sv
// Control sequencer and operand feeder for a binary-serial inner-product PE column.
// Per tile: clear, preload WROWS weights, stream k_len activations (one per 2^IDEPTH window), drain, done.
module pe_seq_inner #(
  parameter int IWIDTH    = 16,
  parameter int IDEPTH    = 4,
  parameter int KWIDTH    = 12,
  parameter int WROWS     = 16,
  parameter int DRAIN_CYC = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [KWIDTH-1:0]        k_len,
  output logic                     busy,
  output logic                     done,
  input  logic                     w_valid,
  input  logic signed [IWIDTH-1:0] w_data,
  output logic                     w_ready,
  input  logic                     i_valid,
  input  logic signed [IWIDTH-1:0] i_data,
  output logic                     i_ready,
  output logic [IDEPTH-1:0]        idx,
  output logic                     mac_done,
  output logic                     en_i,
  output logic                     clr_i,
  output logic                     en_w,
  output logic                     clr_w,
  output logic                     en_o,
  output logic                     clr_o,
  output logic signed [IWIDTH-1:0] ifm,
  output logic signed [IWIDTH-1:0] wght
);

  localparam int CYC = 1 << IDEPTH;
  localparam int BW  = $clog2(WROWS) + 1;
  localparam int DW  = $clog2(DRAIN_CYC) + 1;

  typedef enum logic [2:0] {IDLE, CLR, LOADW, MAC, DRAIN, DONE} state_t;

  state_t              state_reg, state_next;
  logic [KWIDTH-1:0]   klen_reg, klen_next;
  logic [BW-1:0]       beat_reg, beat_next;
  logic [KWIDTH-1:0]   elem_reg, elem_next;
  logic [IDEPTH-1:0]   bit_reg, bit_next;
  logic [DW-1:0]       drain_reg, drain_next;

  // Decoded PE controls; the ports carry these one cycle later.
  logic [IDEPTH-1:0]        idx_next;
  logic                     mac_done_next, en_i_next, en_w_next, en_o_next, clr_next;
  logic signed [IWIDTH-1:0] ifm_next, wght_next;

  assign busy    = (state_reg != IDLE);
  assign done    = (state_reg == DONE);
  assign w_ready = (state_reg == LOADW);
  assign i_ready = (state_reg == MAC) && (bit_reg == '0);

  always_comb begin
    state_next    = state_reg;
    klen_next     = klen_reg;
    beat_next     = beat_reg;
    elem_next     = elem_reg;
    bit_next      = bit_reg;
    drain_next    = drain_reg;
    idx_next      = '0;
    mac_done_next = 1'b0;
    en_i_next     = 1'b0;
    en_w_next     = 1'b0;
    en_o_next     = 1'b0;
    clr_next      = 1'b0;
    ifm_next      = ifm;
    wght_next     = wght;
    case (state_reg)
      IDLE: begin
        if (start) begin
          klen_next  = k_len;
          beat_next  = '0;
          elem_next  = '0;
          bit_next   = '0;
          drain_next = '0;
          state_next = CLR;
        end
      end
      CLR: begin
        clr_next   = 1'b1;
        state_next = (klen_reg == '0) ? DONE : LOADW;
      end
      LOADW: begin
        if (w_valid) begin
          en_w_next = 1'b1;
          wght_next = w_data;
          if (beat_reg == BW'(WROWS - 1)) begin
            beat_next  = '0;
            state_next = MAC;
          end else begin
            beat_next = beat_reg + BW'(1);
          end
        end
      end
      MAC: begin
        en_o_next = 1'b1;
        idx_next  = bit_reg;
        if (bit_reg == '0) begin
          // Only the window start may stall; the rest of the window free-runs.
          if (i_valid) begin
            en_i_next = 1'b1;
            ifm_next  = i_data;
            elem_next = elem_reg + KWIDTH'(1);
            bit_next  = bit_reg + IDEPTH'(1);
          end
        end else begin
          bit_next = bit_reg + IDEPTH'(1);
          if (bit_reg == IDEPTH'(CYC - 1)) begin
            mac_done_next = 1'b1;
            if (elem_reg == klen_reg) state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        en_o_next = 1'b1;
        if (drain_reg == DW'(DRAIN_CYC - 1)) state_next = DONE;
        else drain_next = drain_reg + DW'(1);
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      klen_reg  <= '0;
      beat_reg  <= '0;
      elem_reg  <= '0;
      bit_reg   <= '0;
      drain_reg <= '0;
      idx       <= '0;
      mac_done  <= 1'b0;
      en_i      <= 1'b0;
      clr_i     <= 1'b0;
      en_w      <= 1'b0;
      clr_w     <= 1'b0;
      en_o      <= 1'b0;
      clr_o     <= 1'b0;
      ifm       <= '0;
      wght      <= '0;
    end else begin
      state_reg <= state_next;
      klen_reg  <= klen_next;
      beat_reg  <= beat_next;
      elem_reg  <= elem_next;
      bit_reg   <= bit_next;
      drain_reg <= drain_next;
      idx       <= idx_next;
      mac_done  <= mac_done_next;
      en_i      <= en_i_next;
      clr_i     <= clr_next;
      en_w      <= en_w_next;
      clr_w     <= clr_next;
      en_o      <= en_o_next;
      clr_o     <= clr_next;
      ifm       <= ifm_next;
      wght      <= wght_next;
    end
  end

endmodule

// File: tb/tb_pe_seq_inner.sv
// Directed self-checking bench for pe_seq_inner: per-cycle output traces of each tile
// are compared against hand-derived cycle masks and operand values.
module tb_pe_seq_inner;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [11:0]        k_len;
  logic               busy, done, w_ready, i_ready;
  logic               w_valid, i_valid;
  logic signed [15:0] w_data, i_data;
  logic [3:0]         idx;
  logic               mac_done, en_i, clr_i, en_w, clr_w, en_o, clr_o;
  logic signed [15:0] ifm, wght;

  int n_chk  = 0;
  int n_fail = 0;

  logic [127:0] v_clr, v_clrany, v_enw, v_eni, v_mac, v_eno, v_done, v_busy, v_wr, v_ir, v_any;
  logic [15:0]  r_idx [128];
  logic [15:0]  r_ifm [128];
  logic [15:0]  r_wght[128];

  always #5 clk = ~clk;

  pe_seq_inner dut (
    .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
    .busy(busy), .done(done),
    .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
    .i_valid(i_valid), .i_data(i_data), .i_ready(i_ready),
    .idx(idx), .mac_done(mac_done), .en_i(en_i), .clr_i(clr_i),
    .en_w(en_w), .clr_w(clr_w), .en_o(en_o), .clr_o(clr_o),
    .ifm(ifm), .wght(wght)
  );

  function automatic logic [127:0] mask(input int lo, input int hi);
    logic [127:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic record(input int t);
    v_clr[t]    = clr_i & clr_w & clr_o;
    v_clrany[t] = clr_i | clr_w | clr_o;
    v_enw[t]    = en_w;
    v_eni[t]    = en_i;
    v_mac[t]    = mac_done;
    v_eno[t]    = en_o;
    v_done[t]   = done;
    v_busy[t]   = busy;
    v_wr[t]     = w_ready;
    v_ir[t]     = i_ready;
    v_any[t]    = busy | done | w_ready | i_ready | mac_done | en_i | clr_i | en_w | clr_w | en_o | clr_o;
    r_idx[t]    = 16'(idx);
    r_ifm[t]    = ifm;
    r_wght[t]   = wght;
  endtask

  // Cycle t of a tile: inputs set just after edge t, outputs sampled at the following negedge.
  task automatic run_tile(input int klen, input int ncyc, input int wg_s, input int wg_n,
                          input int ig_s, input int ig_n, input int rst_at,
                          input int s2, input int s3, input int kchg);
    {v_clr, v_clrany, v_enw, v_eni, v_mac, v_eno, v_done, v_busy, v_wr, v_ir, v_any} = '0;
    for (int t = 0; t < ncyc; t++) begin
      start   = (t == 0) || (t == s2) || (t == s3);
      k_len   = (kchg >= 0 && t >= kchg) ? 12'd5 : 12'(klen);
      w_valid = !(t >= wg_s && t < wg_s + wg_n);
      i_valid = !(t >= ig_s && t < ig_s + ig_n);
      rst_n   = (t != rst_at);
      w_data  = 16'hF000 | 16'(t);
      i_data  = 16'h8000 | 16'(t);
      @(negedge clk);
      record(t);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    rst_n = 1'b1;
    $display("tile k_len=%0d cycles=%0d done_cycles=%0h", klen, ncyc, v_done);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; k_len = '0;
    w_valid = 1'b0; i_valid = 1'b0; w_data = '0; i_data = '0;
    @(posedge clk); #1;
    @(negedge clk);
    record(0);
    chk("reset_any",  128'(v_any[0]), 128'd0);
    chk("reset_idx",  128'(r_idx[0]), 128'd0);
    chk("reset_ifm",  128'(r_ifm[0]), 128'd0);
    chk("reset_wght", 128'(r_wght[0]), 128'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Tile 1: k_len=2, no stalls
    run_tile(2, 64, -1, 0, -1, 0, -1, -1, -1, -1);
    chk("t1_clr",   v_clr, mask(2, 2));
    chk("t1_clrany", v_clrany, mask(2, 2));
    chk("t1_enw",   v_enw, mask(3, 18));
    chk("t1_eni",   v_eni, mask(19, 19) | mask(35, 35));
    chk("t1_mac",   v_mac, mask(34, 34) | mask(50, 50));
    chk("t1_eno",   v_eno, mask(19, 58));
    chk("t1_done",  v_done, mask(58, 58));
    chk("t1_busy",  v_busy, mask(1, 58));
    chk("t1_wready", v_wr, mask(2, 17));
    chk("t1_iready", v_ir, mask(18, 18) | mask(34, 34));
    chk("t1_wght3",  128'(r_wght[3]), 128'h F002);
    chk("t1_wght18", 128'(r_wght[18]), 128'h F011);
    chk("t1_ifm19",  128'(r_ifm[19]), 128'h 8012);
    chk("t1_ifm30",  128'(r_ifm[30]), 128'h 8012);
    chk("t1_ifm35",  128'(r_ifm[35]), 128'h 8022);
    chk("t1_idx19",  128'(r_idx[19]), 128'd0);
    chk("t1_idx20",  128'(r_idx[20]), 128'd1);
    chk("t1_idx34",  128'(r_idx[34]), 128'd15);
    chk("t1_idx51",  128'(r_idx[51]), 128'd0);

    // Tile 2: w_valid low in cycles 4..6
    run_tile(2, 70, 4, 3, -1, 0, -1, -1, -1, -1);
    chk("t2_enw",    v_enw, mask(3, 4) | mask(8, 21));
    chk("t2_beats",  128'($countones(v_enw)), 128'd16);
    chk("t2_wght6",  128'(r_wght[6]), 128'h F003);
    chk("t2_wght21", 128'(r_wght[21]), 128'h F014);
    chk("t2_eni",    v_eni, mask(22, 22) | mask(38, 38));
    chk("t2_done",   v_done, mask(61, 61));

    // Tile 3: k_len=1, i_valid low 5 cycles at window start
    run_tile(1, 56, -1, 0, 18, 5, -1, -1, -1, -1);
    for (int c = 19; c <= 23; c++) begin
      chk($sformatf("t3_idx%0d", c), 128'(r_idx[c]), 128'd0);
      chk($sformatf("t3_ifm%0d", c), 128'(r_ifm[c]), 128'h 8025);
    end
    chk("t3_eni",   v_eni, mask(24, 24));
    chk("t3_ifm24", 128'(r_ifm[24]), 128'h 8017);
    chk("t3_idx30", 128'(r_idx[30]), 128'd6);
    chk("t3_mac",   v_mac, mask(39, 39));
    chk("t3_done",  v_done, mask(47, 47));

    // Tile 4: k_len=0 goes straight from CLR to DONE
    run_tile(0, 8, -1, 0, -1, 0, -1, -1, -1, -1);
    chk("t4_done", v_done, mask(2, 2));
    chk("t4_busy", v_busy, mask(1, 2));
    chk("t4_clr",  v_clr, mask(2, 2));
    chk("t4_enw",  v_enw, 128'd0);
    chk("t4_eni",  v_eni, 128'd0);
    chk("t4_eno",  v_eno, 128'd0);
    chk("t4_wr",   v_wr, 128'd0);

    // Tile 5: reset while internal idx=7 (start also high during reset)
    run_tile(2, 40, -1, 0, -1, 0, 25, 25, -1, -1);
    chk("t5_idx25",  128'(r_idx[25]), 128'd6);
    chk("t5_quiet",  v_any & mask(26, 39), 128'd0);
    chk("t5_idx26",  128'(r_idx[26]), 128'd0);
    chk("t5_ifm26",  128'(r_ifm[26]), 128'd0);
    chk("t5_wght26", 128'(r_wght[26]), 128'd0);
    chk("t5_nodone", v_done, 128'd0);

    // Tile 5b: clean tile after the reset
    run_tile(2, 64, -1, 0, -1, 0, -1, -1, -1, -1);
    chk("t5b_wght2", 128'(r_wght[2]), 128'd0);
    chk("t5b_wght3", 128'(r_wght[3]), 128'h F002);
    chk("t5b_enw",   v_enw, mask(3, 18));
    chk("t5b_mac",   v_mac, mask(34, 34) | mask(50, 50));
    chk("t5b_done",  v_done, mask(58, 58));

    // Tile 6: start pulsed while busy and in DONE; k_len changed mid-tile
    run_tile(2, 72, -1, 0, -1, 0, -1, 40, 58, 10);
    chk("t6_done", v_done, mask(58, 58));
    chk("t6_busy", v_busy, mask(1, 58));
    chk("t6_eno",  v_eno, mask(19, 58));
    chk("t6_eni",  v_eni, mask(19, 19) | mask(35, 35));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_seq_inner.md
# pe_seq_inner

Control sequencer and operand feeder sitting directly upstream of a binary-serial inner-product PE column. Per tile, it:
- pulses the clears,
- preloads the weight registers through a valid/ready port,
- streams k_len input activations, each held for one full bit-serial window of 2^IDEPTH cycles,
- drives idx/mac_done/enable/clear lines cycle-exactly,
- drains the array and reports done.

Its PE-side outputs connect one-to-one to the first PE's same-named inputs.

## Interface
- IWIDTH, 16, activation/weight width
- IDEPTH, 4, serial index width; window length CYC = 2^IDEPTH
- KWIDTH, 12, width of k_len
- WROWS, 16, weight beats accepted per tile
- DRAIN_CYC, 8, drain cycles after the last window
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin tile; sampled only in IDLE
- k_len  in  KWIDTH  activations per tile, captured with start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse in DONE state
- w_valid  in  1  weight beat valid
- w_data  in  IWIDTH  signed weight beat
- w_ready  out  1  high in LOADW
- i_valid  in  1  activation valid
- i_data  in  IWIDTH  signed activation
- i_ready  out  1  high in MAC at window start (internal idx==0)
- idx  out  IDEPTH  serial bit index to PE
- mac_done, en_i, clr_i, en_w, clr_w, en_o, clr_o  out  1 each  PE control
- ifm, wght  out  IWIDTH  signed operands to PE

## Operation
- FSM states: IDLE, CLR, LOADW, MAC, DRAIN, DONE.
- IDLE→CLR on start=1. start in any other state is ignored; k_len is captured into an internal register.
- CLR (1 cycle):
  - decode clr_i=clr_w=clr_o=1.
  - Next state: DONE if captured k_len==0, else LOADW.
- LOADW:
  - w_ready=1. Each w_valid&w_ready is one beat: decode en_w=1, wght=w_data.
  - Cycles with w_valid=0 give en_w=0 and wght holds.
  - Beat counter 0..WROWS-1. Leave for MAC in the cycle after beat WROWS-1.
- MAC:
  - Internal idx counts 0..CYC-1 and wraps.
  - At idx==0, i_ready=1.
  - i_valid=1: accept. Decode en_i=1, ifm=i_data, element counter increments, idx advances.
  - i_valid=0: stall. idx stays 0, en_i=0, mac_done=0, ifm holds.
  - idx 1..CYC-1 never stall. mac_done decode=1 exactly when idx==CYC-1.
  - After the idx==CYC-1 cycle of element k_len, go to DRAIN.
- DRAIN: DRAIN_CYC cycles, no handshakes, then DONE.
- DONE: 1 cycle, done=1, then IDLE.
- en_o decode=1 in MAC and DRAIN, 0 elsewhere. idx decode=0 outside MAC.
- Operand width: operands pass unchanged, signed, no extension or saturation.
- Counter widths:
  - element counter is KWIDTH bits, compared to captured k_len.
  - beat counter is clog2(WROWS)+1 bits.

## Timing
- Control/operand outputs (idx, mac_done, en_*, clr_*, ifm, wght) are registered copies of the internal decode, one cycle late.
  - Example: a beat accepted in cycle t gives en_w=1 and wght=beat at t+1.
- busy, done, w_ready, i_ready are decoded combinationally from registered state. Inputs are accepted in the same cycle.
- Stall-free latency, start sampled in cycle 0:
  - CLR = cycle 1
  - LOADW = cycles 2..WROWS+1
  - MAC = WROWS+2 .. WROWS+1+k_len·CYC
  - done at cycle 2+WROWS+k_len·CYC+DRAIN_CYC
  - busy high cycles 1 through that cycle
- Each input stall cycle delays done by exactly one cycle.
- Reset values: state=IDLE, all counters 0. On the cycle after rst_n low, every output is 0 (busy, done, readies, idx, all enables/clears, ifm, wght).
- Reset mid-tile:
  - abandons the tile with no done pulse.
  - start is ignored while rst_n=0.
- start coincident with DONE is ignored. A new tile needs start in IDLE.

## Test plan
- Default params, k_len=2, w_valid/i_valid held high, start at cycle 0 → clr_* high at cycle 2 only.
  - en_w high cycles 3..18, with wght tracking beats.
  - en_i high at cycles 19 and 35; mac_done high at 34 and 50.
  - en_o high cycles 19..58; done at 58.
- Same run with w_valid low for cycles 4..6 → 3 missing en_w cycles; exactly 16 beats still forwarded; done at 61.
- k_len=1, i_valid low for 5 cycles at window start → idx held 0 and en_i=0 for 5 cycles; ifm keeps previous value; done at 47.
- k_len=0 → CLR then DONE: done at cycle 2; en_w, en_i, en_o never high; w_ready never high.
- rst_n low for 1 cycle mid-MAC (idx=7) → next cycle all outputs 0 and state IDLE; no done; a following start runs a full correct tile.
- start pulsed while busy and in the DONE cycle → ignored; k_len change during the tile has no effect; exactly one done per accepted start.
